// File: rtl/ro_deserializer_pkg.sv
// rtl/ro_deserializer_pkg.sv - shared defaults, drain FSM encoding and slot-owner helper
package ro_deserializer_pkg;

  localparam int NCH_DEFAULT     = 8;
  localparam int CNT_W_DEFAULT   = 8;
  localparam int FRAME_W_DEFAULT = 10;

  typedef enum logic {
    DRAIN_IDLE = 1'b0,
    DRAIN_SEND = 1'b1
  } drain_state_t;

  // Trailing-zero count of c; returns nch when c is zero or the owner is out of range.
  function automatic int unsigned slot_owner(input logic [31:0] c, input int unsigned nch);
    int unsigned tz;
    tz = nch;
    for (int i = 31; i >= 0; i--) begin
      if (c[i]) tz = i;
    end
    if (tz > nch) tz = nch;
    return tz;
  endfunction

endpackage

// File: rtl/ro_slot_decoder.sv
// rtl/ro_slot_decoder.sv - local slot counter re-deriving the gray-slot owner each enabled cycle
module ro_slot_decoder
  import ro_deserializer_pkg::*;
#(
  parameter int NCH     = NCH_DEFAULT,
  parameter int FRAME_W = FRAME_W_DEFAULT,
  localparam int CH_W   = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  output logic            slot_valid,
  output logic [CH_W-1:0] slot_ch,
  output logic            frame_end
);

  logic [FRAME_W-1:0] slot_cnt;
  int unsigned        owner;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_cnt <= '0;
    end else if (en) begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // The pre-increment count names the gray bit that toggled on the previous edge.
  always_comb begin
    owner      = slot_owner(32'(slot_cnt), NCH);
    slot_valid = en && (owner < NCH);
    slot_ch    = CH_W'(owner);
    frame_end  = en && (&slot_cnt);
  end

endmodule

// File: rtl/ro_deserializer.sv
// rtl/ro_deserializer.sv - gray-slotted readout demux, per-channel edge counter and frame drain
module ro_deserializer
  import ro_deserializer_pkg::*;
#(
  parameter int NCH     = NCH_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT,
  parameter int FRAME_W = FRAME_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   serial_in,
  output logic [NCH-1:0]         out_bit,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(NCH)-1:0] out_chan,
  output logic [CNT_W-1:0]       out_count,
  output logic                   out_last,
  output logic                   overrun
);

  localparam int CH_W = $clog2(NCH);

  logic            slot_valid;
  logic            frame_end;
  logic [CH_W-1:0] slot_ch;

  logic [NCH-1:0]   last_bit;
  logic [CNT_W-1:0] live_cnt [NCH];
  logic [CNT_W-1:0] live_upd [NCH];
  logic [CNT_W-1:0] shadow   [NCH];
  logic [CH_W-1:0]  idx, idx_nxt;
  drain_state_t     state, state_nxt;
  logic             take_snapshot;

  ro_slot_decoder #(
    .NCH     (NCH),
    .FRAME_W (FRAME_W)
  ) u_slot_decoder (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .slot_valid (slot_valid),
    .slot_ch    (slot_ch),
    .frame_end  (frame_end)
  );

  // The demuxed level doubles as the previous-level reference for edge detection.
  assign out_bit = last_bit;

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      live_upd[k] = live_cnt[k];
      if (slot_valid && (slot_ch == CH_W'(k)) && serial_in && !last_bit[k] &&
          (live_cnt[k] != {CNT_W{1'b1}})) begin
        live_upd[k] = live_cnt[k] + 1'b1;
      end
    end
  end

  assign take_snapshot = frame_end && (state == DRAIN_IDLE);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      DRAIN_IDLE: begin
        if (take_snapshot) begin
          state_nxt = DRAIN_SEND;
          idx_nxt   = '0;
        end
      end
      DRAIN_SEND: begin
        if (out_ready) begin
          if (idx == CH_W'(NCH - 1)) state_nxt = DRAIN_IDLE;
          else                       idx_nxt   = idx + 1'b1;
        end
      end
      default: state_nxt = DRAIN_IDLE;
    endcase
  end

  assign out_valid = (state == DRAIN_SEND);
  assign out_chan  = idx;
  assign out_count = shadow[idx];
  assign out_last  = out_valid && (idx == CH_W'(NCH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= DRAIN_IDLE;
      idx      <= '0;
      overrun  <= 1'b0;
      last_bit <= '0;
      for (int k = 0; k < NCH; k++) begin
        live_cnt[k] <= '0;
        shadow[k]   <= '0;
      end
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      // A frame ending mid-drain loses its snapshot; the drain in flight is untouched.
      if (frame_end && (state == DRAIN_SEND)) overrun <= 1'b1;
      if (slot_valid) last_bit[slot_ch] <= serial_in;
      for (int k = 0; k < NCH; k++) begin
        live_cnt[k] <= frame_end ? '0 : live_upd[k];
        if (take_snapshot) shadow[k] <= live_upd[k];
      end
    end
  end

endmodule

// File: doc/ro_deserializer.md
Name: ro_deserializer

Overview:
- Receive-end decoder for the 8-channel gray-slotted readout bus.
- On the transmitter side, the channel whose gray-counter bit toggles on a global clock edge drives the single muxed serial line for that cycle.
- This block re-derives the slot owner locally and demultiplexes the line into per-channel levels.
- It counts comparator rising edges per channel over a fixed frame, then streams the frame's counts out on a valid/ready interface, one channel per beat.

Parameters:
- NCH, 8: number of readout channels (slots); must be at most FRAME_W.
- CNT_W, 8: width of each per-channel event counter; counters saturate.
- FRAME_W, 10: frame length is 2**FRAME_W enabled clock cycles.

Ports:
- clk  input  1  global readout clock; same clock as the transmitter gray counter.
- reset  input  1  asynchronous, active-low reset; released together with the transmitter gray counter reset.
- en  input  1  enable; slot counter advances and sampling occurs only when high.
- serial_in  input  1  muxed serial readout line.
- out_bit  output  NCH  latest demultiplexed level per channel.
- out_valid  output  1  count beat valid.
- out_ready  input  1  downstream accepts beat.
- out_chan  output  $clog2(NCH)  channel index of the current beat.
- out_count  output  CNT_W  rising-edge count of that channel for the drained frame.
- out_last  output  1  high on the beat for channel NCH-1.
- overrun  output  1  sticky; a frame snapshot was dropped.

Behaviour:
- Reset (async, reset=0):
  - slot_cnt, live counts, last-bit registers, shadow counts, idx and all outputs go to 0.
  - FSM goes to IDLE.
- Slot counter:
  - slot_cnt is FRAME_W bits, incremented on each posedge clk with en=1.
  - It wraps from 2**FRAME_W-1 to 0.
- Slot decode, evaluated at a posedge with en=1 using the pre-increment value c:
  - If c=0, the slot is idle and serial_in is ignored.
  - Otherwise ch = number of trailing zeros of c (the gray bit that toggled on the previous edge).
  - If ch >= NCH, the slot is idle.
  - Channel k therefore owns every 2**(k+1)-th cycle, e.g. ch0 at c=1,3,5…, ch1 at c=2,6,10…
- Sampling, one cycle latency:
  - The owning channel's out_bit[ch] and last_bit[ch] take serial_in on that edge.
  - Non-owning channels hold their values.
- Edge count:
  - If serial_in=1 and last_bit[ch]=0, live_cnt[ch] increments, saturating at 2**CNT_W-1.
  - last_bit persists across frame boundaries.
- Frame end, on the edge where c=2**FRAME_W-1 and en=1:
  - If the FSM is IDLE: shadow[k] <= live_cnt[k] for all k, including this cycle's update (next-state value); idx <= 0; go to SEND.
  - If the FSM is in SEND: overrun <= 1 and the snapshot is discarded; the in-progress drain continues unchanged.
  - In both cases live_cnt clears to 0 for the next frame.
- Drain FSM:
  - IDLE: out_valid=0.
  - SEND: out_valid=1, out_chan=idx, out_count=shadow[idx], out_last=(idx==NCH-1).
  - All outputs stay stable while out_ready=0.
  - On out_valid and out_ready: if idx==NCH-1 go to IDLE, else idx++.
  - There is no bubble between beats.
- en=0: slot_cnt, live counts and out_bit freeze; no frame end can occur; the drain FSM keeps operating.
- overrun clears only on reset.
- Reset mid-drain aborts the drain immediately; out_valid drops asynchronously.

Decomposition:
- Shared package holds:
  - NCH/CNT_W/FRAME_W defaults.
  - Drain FSM state encoding (IDLE, SEND).
  - A trailing-zero-count function returning NCH for "idle".
- One natural sub-module: ro_slot_decoder.
  - Contents: slot_cnt plus trailing-zero logic.
  - Outputs: slot_valid, slot_ch, frame_end.
  - Reusable by future gray-slotted receivers.

Test Plan:
1. Reset with en=1 and serial_in=1 held throughout -> while reset=0, out_valid=0, overrun=0, out_bit=0; after release, the first edge (c=0) leaves out_bit unchanged.
2. Drive serial_in=1 only in the cycle with c=4 -> after that edge out_bit=8'b0000_0100; all other bits stay 0.
3. Full frame with ch0 slots alternating 1,0 and ch1 slots alternating 1,0, others 0 -> drain beats with out_ready=1 give chan0=255 (saturated from 256), chan1=128, chan2..7=0; out_last on beat 7; 8 consecutive valid cycles.
4. Hold out_ready=0 through a second frame end -> beat 0 values stay stable and overrun=1; releasing ready drains frame-1 counts; frame-2 counts never appear.
5. Deassert en for 50 cycles mid-frame -> slot_cnt and counts freeze; the frame ends 50 cycles later than nominal, and counts match the en-masked pattern.
6. Assert reset during drain beat 3 -> out_valid=0 immediately; after release, the first frame drains fresh counts and overrun=0.
